// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin share of the single data-memory port between the core (port 0) and the loader/debug port (port 1).
// Latency: gnt one cycle after acceptance, rvalid LATENCY cycles after gnt; the port is occupied for LATENCY+1 cycles.
// Backpressure: requesters hold req until gnt; req is only sampled while idle, and a tie loser that keeps req high wins the next arbitration.
module dmem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              wen0,
    input  logic              wen1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_wen_D,
    output logic [ADDR_W-1:0] mem_addr_D,
    output logic [DATA_W-1:0] mem_wdata_D,
    input  logic [DATA_W-1:0] mem_rdata_D,
    output logic              busy
);

    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    // Hold cycles minus one: the counter reaches zero on the last access cycle.
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        cnt;
    logic              last;
    logic              sel;
    logic              lat_wen;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              any_req;
    logic              win;

    // Winner selection: a lone requester wins; on a tie the port that did not win last time wins.
    always_comb begin
        any_req = req0 | req1;
        win     = (req0 && req1) ? ~last : req1;
    end

    // State register; reset drops straight back to IDLE, abandoning any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: accept when any request is present, release after the final hold cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ACCESS;
            ACCESS:  if (cnt == 4'd0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Memory-side outputs: driven from the latched request only while ACCESS, write strobe on the last cycle only.
    always_comb begin
        busy        = (state == ACCESS);
        mem_wen_D   = busy & lat_wen & (cnt == 4'd0);
        mem_addr_D  = busy ? lat_addr : '0;
        mem_wdata_D = busy ? lat_wdata : '0;
    end

    // Request latch, hold counter, round-robin history and the per-port response pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= 4'd0;
            last      <= 1'b1;
            sel       <= 1'b0;
            lat_wen   <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
        end else begin
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            if (state == IDLE) begin
                if (any_req) begin
                    sel       <= win;
                    last      <= win;
                    lat_wen   <= win ? wen1 : wen0;
                    lat_addr  <= win ? addr1 : addr0;
                    lat_wdata <= win ? wdata1 : wdata0;
                    cnt       <= CNT_INIT;
                    gnt0      <= ~win;
                    gnt1      <= win;
                end
            end else if (cnt == 4'd0) begin
                rvalid0 <= ~sel;
                rvalid1 <= sel;
                if (!lat_wen) begin
                    if (sel) begin
                        rdata1 <= mem_rdata_D;
                    end else begin
                        rdata0 <= mem_rdata_D;
                    end
                end
            end else begin
                cnt <= cnt - 4'd1;
            end
        end
    end

endmodule
